pipe_hazard_ctrl: RTL
=====================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter MULT_CYCLES, default 5: E-stage cycles a mult/multu occupies the MDU; legal range 2..15.
REQ-002 Parameter DIV_CYCLES, default 10: E-stage cycles a div/divu occupies the MDU; legal range 2..15.
REQ-003 clk  input  1  clock; all state updates on posedge clk.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 rs_D, rt_D  input  5 each  source register numbers of the D-stage instruction.
REQ-006 tuse_rs_D, tuse_rt_D  input  2 each  cycles until the D instruction needs rs/rt; 3 = never used.
REQ-007 wreg_E, wreg_M  input  5 each  destination register of the E/M instruction; 0 = no write.
REQ-008 tnew_E, tnew_M  input  2 each  cycles until the E/M result is available (0 = ready now).
REQ-009 md_start_E  input  1  E-stage instruction is mult/multu/div/divu, valid this cycle.
REQ-010 md_is_div_E  input  1  qualifies md_start_E: 1 = div/divu, 0 = mult/multu.
REQ-011 md_use_D  input  1  D-stage instruction is mult/div/mfhi/mflo/mthi/mtlo.
REQ-012 pc_en  output  1  PC register write enable.
REQ-013 d_en  output  1  IF/ID register write enable.
REQ-014 e_clr  output  1  ID/EX register synchronous clear (bubble insert).
REQ-015 md_busy  output  1  MDU occupied.
REQ-016 stall_cnt  output  32  count of stalled cycles (see Configuration).

Function
REQ-017 hit_rs = (rs_D!=0) & ((rs_D==wreg_E & tuse_rs_D<tnew_E) | (rs_D==wreg_M & tuse_rs_D<tnew_M)); hit_rt identical on rt.
REQ-018 stall = hit_rs | hit_rt | (md_use_D & md_busy); combinational, same-cycle.
REQ-019 pc_en = ~stall; d_en = ~stall; e_clr = stall.
REQ-020 MDU FSM states IDLE and BUSY, plus 4-bit down-counter cnt.
REQ-021 IDLE & md_start_E: next state BUSY, cnt <= (md_is_div_E ? DIV_CYCLES : MULT_CYCLES) - 1.
REQ-022 BUSY: cnt decrements each cycle; when cnt==1 next state IDLE, cnt <= 0.
REQ-023 md_busy = (state==BUSY) | md_start_E; total busy duration = MULT_CYCLES or DIV_CYCLES cycles including the start cycle.
REQ-024 md_start_E while BUSY is illegal upstream; SHALL be ignored (no reload, no extension).
REQ-025 e_clr asserted in the md_start_E cycle does not cancel the started operation.

Reset
REQ-026 Reset cycle: state <= IDLE, cnt <= 0, stall_cnt <= 0.
REQ-027 While reset is high: pc_en=1, d_en=1, e_clr=0, md_busy=0, regardless of other inputs.
REQ-028 Reset mid-operation (BUSY) aborts the operation; md_busy=0 on the first cycle after reset deasserts unless md_start_E.

Configuration
REQ-029 Macro HAZ_PERF_CNT_EN defined: stall_cnt increments by 1 on each posedge where stall=1 and reset=0; wraps 0xFFFFFFFF -> 0.
REQ-030 Macro HAZ_PERF_CNT_EN undefined: no counter register; stall_cnt tied to 0.

Structure
REQ-031 Package pipe_ctrl_pkg holds: MDU state encoding (IDLE=0, BUSY=1), TUSE_NEVER=3, default MULT_CYCLES/DIV_CYCLES constants.
REQ-032 One sub-module md_busy_timer holds the FSM and counter (REQ-020..025, REQ-028); stall logic stays in the top.

Verification
REQ-033 rs_D=8, tuse_rs_D=0, wreg_E=8, tnew_E=2 -> pc_en=0, d_en=0, e_clr=1 that cycle; with tnew_E=0 -> no stall.
REQ-034 rs_D=0, wreg_E=0, tuse=0, tnew_E=2 -> no stall ($zero never stalls).
REQ-035 md_start_E=1, md_is_div_E=0 for one cycle (defaults) -> md_busy high exactly 5 cycles; md_use_D=1 throughout -> stall high exactly those 5 cycles.
REQ-036 div start, reset asserted on busy cycle 4 -> md_busy=0 during reset and after; next md_start_E with mult -> 5 busy cycles.
REQ-037 md_start_E pulsed again on busy cycle 3 of a div -> busy still ends after 10 total cycles.
REQ-038 With HAZ_PERF_CNT_EN: 3 load-use stalls plus one 5-cycle MDU stall -> stall_cnt=8; without macro -> stall_cnt=0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller and its
// multiply/divide busy timer.
package pipe_ctrl_pkg;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  // A tuse of 3 means the operand is never read, so it can never be
  // younger than any tnew (max 3) and never causes a stall.
  localparam logic [1:0] TUSE_NEVER = 2'd3;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  localparam int CNT_W = 4;

  // One source operand conflicts with an in-flight producer when the
  // producer writes the same non-zero register and its result arrives
  // later than the consumer needs it.
  function automatic logic src_hit(
    input logic [4:0] src,
    input logic [1:0] tuse,
    input logic [4:0] wreg_e,
    input logic [1:0] tnew_e,
    input logic [4:0] wreg_m,
    input logic [1:0] tnew_m
  );
    logic hit_e;
    logic hit_m;
    hit_e = (src == wreg_e) && (tuse < tnew_e);
    hit_m = (src == wreg_m) && (tuse < tnew_m);
    return (src != 5'd0) && (tuse != TUSE_NEVER) && (hit_e || hit_m);
  endfunction

endpackage

// File: rtl/md_busy_timer.sv
// Tracks how long the multiply/divide unit stays occupied after an E-stage
// mult/div issues; a second start while already busy is ignored.
module md_busy_timer
  import pipe_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic md_start_E,
  input  logic md_is_div_E,
  output logic md_busy
);

  // The start cycle is itself busy, so the counter covers the remaining N-1.
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  md_state_e        state;
  md_state_e        state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; the comb block below uses blocking assignments.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= MD_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // NOTE: every output of this block gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      MD_IDLE: begin
        if (md_start_E) begin
          state_nxt = MD_BUSY;
          cnt_nxt   = md_is_div_E ? DIV_LOAD : MULT_LOAD;
        end
      end
      MD_BUSY: begin
        if (cnt <= CNT_W'(1)) begin
          state_nxt = MD_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_nxt = MD_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign md_busy = !reset && ((state == MD_BUSY) || md_start_E);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/bubble control for register hazards and the busy MDU.
// Optional stall performance counter enabled by defining HAZ_PERF_CNT_EN.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs_D,
  input  logic [4:0]  rt_D,
  input  logic [1:0]  tuse_rs_D,
  input  logic [1:0]  tuse_rt_D,
  input  logic [4:0]  wreg_E,
  input  logic [4:0]  wreg_M,
  input  logic [1:0]  tnew_E,
  input  logic [1:0]  tnew_M,
  input  logic        md_start_E,
  input  logic        md_is_div_E,
  input  logic        md_use_D,
  output logic        pc_en,
  output logic        d_en,
  output logic        e_clr,
  output logic        md_busy,
  output logic [31:0] stall_cnt
);

  logic hit_rs;
  logic hit_rt;
  logic md_wait;
  logic stall;

  md_busy_timer #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md_busy_timer (
    .clk         (clk),
    .reset       (reset),
    .md_start_E  (md_start_E),
    .md_is_div_E (md_is_div_E),
    .md_busy     (md_busy)
  );

  assign hit_rs  = src_hit(rs_D, tuse_rs_D, wreg_E, tnew_E, wreg_M, tnew_M);
  assign hit_rt  = src_hit(rt_D, tuse_rt_D, wreg_E, tnew_E, wreg_M, tnew_M);
  assign md_wait = md_use_D && md_busy;

  // Reset forces a free-running pipeline regardless of the hazard inputs.
  assign stall = !reset && (hit_rs || hit_rt || md_wait);

  assign pc_en = !stall;
  assign d_en  = !stall;
  assign e_clr = stall;

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (stall) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule
